pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

Sequencing controller for the 4-bit/8-bit window pattern matcher. It accepts a stream of bytes over a valid/ready handshake and walks one shared 4-bit comparator across the five alignment offsets of each byte, one offset per cycle. For each byte it reports a per-offset hit mask and the lowest matching offset. It also keeps a running match count. It sits between the byte source and any downstream consumer of match results.

## Interface
- DATA_W, 8, input byte width (fixed at 8; offsets 0..DATA_W-PAT_W)
- PAT_W, 4, pattern width (fixed at 4)
- CNT_W, 8, width of match_count

- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- cfg_we  input  1  write cfg_pattern into pattern register; honoured only in IDLE
- cfg_pattern  input  4  pattern value
- start  input  1  begin a scan session; honoured only in IDLE
- in_valid / in_ready  input / output  1 / 1  byte handshake
- in_data  input  8  byte to scan
- in_last  input  1  marks final byte of session
- res_valid / res_ready  output / input  1 / 1  result handshake
- res_hit  output  1  any offset matched
- res_mask  output  5  bit k set when in_data[k+3:k] == pattern
- res_offset  output  3  lowest set index of res_mask; 0 when res_hit=0
- match_count  output  CNT_W  total matches this session, saturating
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at session end

## Operation
- States: IDLE, ACCEPT, SCAN, REPORT, DONE.
- IDLE:
  - in_ready=0.
  - cfg_we loads the pattern register.
  - start clears match_count and moves to ACCEPT.
  - When cfg_we and start are asserted in the same cycle, the new pattern is used.
- ACCEPT:
  - in_ready=1.
  - On in_valid&in_ready: latch byte and in_last, set offset=0, clear mask, move to SCAN.
- SCAN:
  - Each cycle, compare byte[offset+3:offset] against the pattern and write the result into mask[offset].
  - After offset 4, move to REPORT.
  - offset is a 3-bit counter and never exceeds 4.
- REPORT:
  - res_valid=1 and all res_* outputs are held stable until res_ready.
  - On handshake: match_count += popcount(mask), saturating at 2^CNT_W-1. Then go to DONE if the latched last flag is set, else to ACCEPT.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
- cfg_we and start are ignored when busy=1.
- rst in any state:
  - Returns to IDLE.
  - Clears pattern, mask, offset, match_count and all outputs.
  - Drops any in-flight byte; no result is emitted for it.

## Timing
- Reset values: in_ready=0, res_valid=0, res_hit=0, res_mask=0, res_offset=0, match_count=0, busy=0, done=0.
- Byte accepted at edge t: SCAN occupies t+1..t+5, and res_valid rises after edge t+5.
- With res_ready held high: the result handshake completes at edge t+6, and the next byte can be accepted at edge t+7.
- Peak throughput: one byte per 7 cycles.
- in_ready is registered and is low in every state except ACCEPT.
- match_count updates on the edge of the result handshake and is visible the following cycle.

## Configuration
- PATTERN_SCAN_EARLY_EXIT_EN defined:
  - SCAN goes to REPORT on the first matching offset.
  - res_mask then contains only that single bit, and match_count increments by 1 per hit byte.
  - A byte with a hit at offset k produces res_valid after edge t+k+1.
- Not defined: all five offsets are always scanned, with fixed latency as described under Timing.

## Structure
- Shared package pattern_scan_pkg holds:
  - state enum (IDLE, ACCEPT, SCAN, REPORT, DONE)
  - constants PAT_W=4, DATA_W=8, NUM_OFFSETS=5
- One sub-module, pattern_cmp4:
  - combinational 4-bit equality, window[3:0] vs pattern[3:0]
  - instantiated once and shared across offsets through a window mux driven by offset.

## Test plan
- Pattern 4'b1010, single byte 8'hAA with in_last=1 -> res_mask=5'b10101, res_offset=0, res_hit=1, match_count=3, done pulses once.
- Pattern 4'b0011, byte 8'b0011_0000 -> res_mask=5'b10000, res_offset=4, match_count=1. With EARLY_EXIT_EN, res_valid arrives 5 cycles after accept.
- Pattern 4'b1111, byte 8'h00 -> res_hit=0, res_mask=0, res_offset=0, match_count unchanged.
- Backpressure:
  - Hold res_ready=0 for 3 cycles in REPORT -> res_* remain constant and in_ready stays 0.
  - Then release -> exactly one handshake occurs and the FSM returns to ACCEPT.
- Saturation: CNT_W=2, pattern 4'b0000, three bytes 8'h00 -> each byte contributes 5 matches, and match_count saturates at 3.
- Reset and config during a session:
  - Assert rst in the 3rd SCAN cycle -> next cycle all outputs are at reset values and no result is emitted.
  - cfg_we while busy -> pattern is unchanged.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// Shared definitions for the pattern scan controller: FSM state encoding,
// datapath widths and small mask helpers used by the top level.
package pattern_scan_pkg;

  localparam int PAT_W       = 4;
  localparam int DATA_W      = 8;
  localparam int NUM_OFFSETS = DATA_W - PAT_W + 1;

  localparam logic [2:0] LAST_OFFSET = 3'(NUM_OFFSETS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    SCAN,
    REPORT,
    DONE
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [2:0] lowest_set(input logic [NUM_OFFSETS-1:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = NUM_OFFSETS - 1; k >= 0; k--) begin
      if (m[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  // Number of set bits in an offset mask.
  function automatic logic [2:0] count_ones(input logic [NUM_OFFSETS-1:0] m);
    logic [2:0] n;
    n = 3'd0;
    for (int k = 0; k < NUM_OFFSETS; k++) begin
      n = n + {2'b00, m[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Bundle of the configuration, byte-input and result handshake signals of
// pattern_scan_ctrl. master = byte source / result consumer, slave = controller.
interface pattern_scan_ctrl_if #(
  parameter int CNT_W = 8
);
  import pattern_scan_pkg::*;

  logic                   cfg_we;
  logic [PAT_W-1:0]       cfg_pattern;
  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic                   in_last;
  logic                   res_valid;
  logic                   res_ready;
  logic                   res_hit;
  logic [NUM_OFFSETS-1:0] res_mask;
  logic [2:0]             res_offset;
  logic [CNT_W-1:0]       match_count;
  logic                   busy;
  logic                   done;

  modport master (
    output cfg_we, cfg_pattern, start, in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_hit, res_mask, res_offset, match_count,
           busy, done
  );

  modport slave (
    input  cfg_we, cfg_pattern, start, in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_hit, res_mask, res_offset, match_count,
           busy, done
  );

endinterface

// File: rtl/pattern_cmp4.sv
// Combinational 4-bit window/pattern equality comparator, shared by the
// scan controller across all alignment offsets.
module pattern_cmp4 (
  input  logic [3:0] i_window,
  input  logic [3:0] i_pattern,
  output logic       o_match
);

  assign o_match = (i_window == i_pattern);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Pattern scan sequencing controller. Accepts bytes over valid/ready, walks a
// single 4-bit comparator across the five offsets of each byte (one per
// cycle), reports the hit mask / lowest offset and keeps a saturating match
// count per session.
// Optional build macro PATTERN_SCAN_EARLY_EXIT_EN: stop scanning a byte at
// its first matching offset and report only that offset.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  pattern_scan_ctrl_if.slave bus
);

  localparam int SUM_W = CNT_W + 3;
  localparam logic [SUM_W-1:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

  state_t                 r_state;
  state_t                 w_state_next;

  logic [PAT_W-1:0]       r_pattern;
  logic [DATA_W-1:0]      r_byte;
  logic                   r_last;
  logic [2:0]             r_offset;
  logic [NUM_OFFSETS-1:0] r_mask;
  logic [CNT_W-1:0]       r_count;
  logic                   r_in_ready;
  logic                   r_res_valid;
  logic                   r_busy;
  logic                   r_done;

  logic [DATA_W-1:0]      w_shifted;
  logic [PAT_W-1:0]       w_window;
  logic                   w_match;
  logic [NUM_OFFSETS-1:0] w_sel;
  logic                   w_scan_exit;
  logic                   w_accept;
  logic                   w_res_hs;
  logic [SUM_W-1:0]       w_count_sum;
  logic [CNT_W-1:0]       w_count_sat;

  // Window mux: the current offset selects which 4 bits feed the comparator.
  assign w_shifted = r_byte >> r_offset;
  assign w_window  = w_shifted[PAT_W-1:0];

  pattern_cmp4 u_cmp (
    .i_window  (w_window),
    .i_pattern (r_pattern),
    .o_match   (w_match)
  );

  // One-hot decode of the offset, used to set the matching mask bit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OFFSETS; gi++) begin : g_sel
      assign w_sel[gi] = (r_offset == 3'(gi));
    end
  endgenerate

`ifdef PATTERN_SCAN_EARLY_EXIT_EN
  assign w_scan_exit = w_match || (r_offset == LAST_OFFSET);
`else
  assign w_scan_exit = (r_offset == LAST_OFFSET);
`endif

  assign w_accept = (r_state == ACCEPT) && bus.in_valid;
  assign w_res_hs = (r_state == REPORT) && bus.res_ready;

  assign w_count_sum = SUM_W'(r_count) + SUM_W'(count_ones(r_mask));
  assign w_count_sat = (w_count_sum > CNT_MAX) ? {CNT_W{1'b1}}
                                               : w_count_sum[CNT_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = ACCEPT;
      ACCEPT:  if (bus.in_valid) w_state_next = SCAN;
      SCAN:    if (w_scan_exit) w_state_next = REPORT;
      REPORT:  if (bus.res_ready) w_state_next = r_last ? DONE : ACCEPT;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and registered status outputs (decoded from the next state so
  // they line up with the state they describe).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern   <= '0;
      r_byte      <= '0;
      r_last      <= 1'b0;
      r_offset    <= '0;
      r_mask      <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_next == ACCEPT);
      r_res_valid <= (w_state_next == REPORT);
      r_busy      <= (w_state_next != IDLE);
      r_done      <= (w_state_next == DONE);

      if (r_state == IDLE && bus.cfg_we) r_pattern <= bus.cfg_pattern;
      if (r_state == IDLE && bus.start)  r_count   <= '0;

      if (w_accept) begin
        r_byte   <= bus.in_data;
        r_last   <= bus.in_last;
        r_offset <= '0;
        r_mask   <= '0;
      end

      if (r_state == SCAN) begin
        // Mask is cleared on accept, so with early exit only one bit can land.
        if (w_match) r_mask <= r_mask | w_sel;
        if (!w_scan_exit) r_offset <= r_offset + 3'd1;
      end

      if (w_res_hs) r_count <= w_count_sat;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_mask    = r_mask;
  assign bus.res_hit     = |r_mask;
  assign bus.res_offset  = lowest_set(r_mask);
  assign bus.match_count = r_count;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl. Expected results come from a
// behavioural model (shift-and-compare per offset, plain saturating sums).
// Follows PATTERN_SCAN_EARLY_EXIT_EN when it is defined for the build.
module tb_pattern_scan_ctrl;

`ifdef PATTERN_SCAN_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pattern_scan_ctrl_if #(.CNT_W(8)) bus8 ();
  pattern_scan_ctrl_if #(.CNT_W(2)) bus2 ();

  pattern_scan_ctrl #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  pattern_scan_ctrl #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // ---------------- reference model ----------------
  function automatic logic [4:0] ref_mask(input logic [7:0] b, input logic [3:0] p);
    logic [4:0] m;
    logic [4:0] first;
    m = '0;
    for (int k = 0; k < 5; k++) begin
      if (((b >> k) & 8'h0F) == {4'h0, p}) m[k] = 1'b1;
    end
    if (!EARLY) return m;
    first = '0;
    for (int k = 4; k >= 0; k--) begin
      if (m[k]) first = 5'(1 << k);
    end
    return first;
  endfunction

  function automatic int ref_lowest(input logic [4:0] m);
    for (int k = 0; k < 5; k++) begin
      if (m[k]) return k;
    end
    return 0;
  endfunction

  function automatic int ref_latency(input logic [7:0] b, input logic [3:0] p);
    logic [4:0] m;
    m = ref_mask(b, p);
    if (EARLY && (m != 0)) return ref_lowest(m) + 1;
    return 5;
  endfunction

  // ---------------- drivers ----------------
  task automatic start_session(input logic [3:0] pat);
    @(posedge clk); #1;
    bus8.cfg_we = 1'b1; bus8.cfg_pattern = pat; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.cfg_we = 1'b0; bus8.start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l, output int t_acc, output bit ok);
    ok = 1'b0; t_acc = 0;
    bus8.in_valid = 1'b1; bus8.in_data = d; bus8.in_last = l;
    for (int i = 0; i < 40; i++) begin
      if (bus8.in_ready) begin
        @(posedge clk); #1;
        t_acc = cyc; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus8.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int t_val, output bit ok);
    ok = 1'b0; t_val = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus8.res_valid) begin
        t_val = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  // One session of bytes with res_ready high; checks every result inline.
  task automatic run_session(input string name, input logic [3:0] pat, input bytes_t data);
    int exp_cnt, t_acc, t_prev, gap_exp, t_val;
    bit ok;
    logic [4:0] em;
    logic l;
    exp_cnt = 0; t_prev = 0; gap_exp = 0;
    start_session(pat);
    for (int i = 0; i < data.size(); i++) begin
      l = (i == data.size() - 1);
      push_byte(data[i], l, t_acc, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL %s accept byte %0d: in_ready never high", name, i);
        return;
      end
      if (i > 0) begin
        checks++;
        if ((t_acc - t_prev) !== gap_exp) begin
          errors++; $display("FAIL %s accept_gap byte %0d: got %0d expected %0d", name, i, t_acc - t_prev, gap_exp);
        end
      end
      wait_valid(t_val, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL %s res_valid byte %0d: never asserted", name, i);
        return;
      end
      em = ref_mask(data[i], pat);
      checks++;
      if (bus8.res_mask !== em) begin
        errors++; $display("FAIL %s res_mask byte %02h pat %h: got %b expected %b", name, data[i], pat, bus8.res_mask, em);
      end
      checks++;
      if (bus8.res_hit !== (em != 0)) begin
        errors++; $display("FAIL %s res_hit byte %02h: got %b expected %b", name, data[i], bus8.res_hit, em != 0);
      end
      checks++;
      if (int'(bus8.res_offset) !== ref_lowest(em)) begin
        errors++; $display("FAIL %s res_offset byte %02h: got %0d expected %0d", name, data[i], bus8.res_offset, ref_lowest(em));
      end
      checks++;
      if ((t_val - t_acc) !== ref_latency(data[i], pat)) begin
        errors++; $display("FAIL %s latency byte %02h: got %0d expected %0d", name, data[i], t_val - t_acc, ref_latency(data[i], pat));
      end
      exp_cnt = exp_cnt + $countones(em);
      if (exp_cnt > 255) exp_cnt = 255;
      gap_exp = ref_latency(data[i], pat) + 2;
      t_prev = t_acc;
      @(negedge clk);
      checks++;
      if (int'(bus8.match_count) !== exp_cnt) begin
        errors++; $display("FAIL %s match_count after byte %0d: got %0d expected %0d", name, i, bus8.match_count, exp_cnt);
      end
      checks++;
      if ({bus8.done, bus8.in_ready} !== (l ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL %s post_handshake {done,in_ready}: got %b expected %b", name, {bus8.done, bus8.in_ready}, l ? 2'b10 : 2'b01);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus8.busy, bus8.done} !== 2'b00) begin
      errors++; $display("FAIL %s session_end {busy,done}: got %b expected 00", name, {bus8.busy, bus8.done});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus8.in_ready, bus8.res_valid, bus8.res_hit, bus8.res_mask, bus8.res_offset, bus8.match_count, bus8.busy, bus8.done} !== 21'd0) begin
      errors++; $display("FAIL reset_outputs dut8: got %b expected all zero",
        {bus8.in_ready, bus8.res_valid, bus8.res_hit, bus8.res_mask, bus8.res_offset, bus8.match_count, bus8.busy, bus8.done});
    end
    checks++;
    if ({bus2.in_ready, bus2.res_valid, bus2.res_mask, bus2.match_count, bus2.busy, bus2.done} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs dut2: got %b expected all zero",
        {bus2.in_ready, bus2.res_valid, bus2.res_mask, bus2.match_count, bus2.busy, bus2.done});
    end
  endtask

  task automatic test_directed();
    bytes_t q;
    q = '{8'hAA};        run_session("aa_1010", 4'b1010, q);
    q = '{8'b0011_0000}; run_session("30_0011", 4'b0011, q);
    q = '{8'h00};        run_session("00_1111", 4'b1111, q);
    q = '{8'h0F, 8'hF0, 8'hFF}; run_session("multi_1111", 4'b1111, q);
  endtask

  task automatic test_backpressure();
    int t_acc, t_val;
    bit ok;
    logic [8:0] snap;
    logic [4:0] em;
    start_session(4'b1010);
    bus8.res_ready = 1'b0;
    push_byte(8'hAA, 1'b0, t_acc, ok);
    wait_valid(t_val, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL backpressure res_valid: never asserted");
      bus8.res_ready = 1'b1;
      return;
    end
    snap = {bus8.res_hit, bus8.res_mask, bus8.res_offset};
    em = ref_mask(8'hAA, 4'b1010);
    checks++;
    if (snap !== {em != 0, em, 3'(ref_lowest(em))}) begin
      errors++; $display("FAIL backpressure result: got %b expected %b", snap, {em != 0, em, 3'(ref_lowest(em))});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus8.res_valid, bus8.in_ready, bus8.res_hit, bus8.res_mask, bus8.res_offset} !== {2'b10, snap}) begin
        errors++; $display("FAIL backpressure hold cycle %0d: got %b expected %b", i,
          {bus8.res_valid, bus8.in_ready, bus8.res_hit, bus8.res_mask, bus8.res_offset}, {2'b10, snap});
      end
    end
    bus8.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus8.res_valid, bus8.in_ready, bus8.match_count} !== {2'b01, 8'($countones(em))}) begin
      errors++; $display("FAIL backpressure release {valid,ready,count}: got %b expected %b",
        {bus8.res_valid, bus8.in_ready, bus8.match_count}, {2'b01, 8'($countones(em))});
    end
    @(negedge clk);
    checks++;
    if ({bus8.res_valid, bus8.match_count} !== {1'b0, 8'($countones(em))}) begin
      errors++; $display("FAIL backpressure single_handshake {valid,count}: got %b expected %b",
        {bus8.res_valid, bus8.match_count}, {1'b0, 8'($countones(em))});
    end
    push_byte(8'h00, 1'b1, t_acc, ok);
    wait_valid(t_val, ok);
    @(negedge clk);
    checks++;
    if (bus8.done !== 1'b1) begin
      errors++; $display("FAIL backpressure done: got %b expected 1", bus8.done);
    end
    @(negedge clk);
  endtask

  task automatic test_cfg_busy();
    int t_acc, t_val;
    bit ok;
    start_session(4'b0101);
    @(posedge clk); #1;
    bus8.cfg_we = 1'b1; bus8.cfg_pattern = 4'b1111; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.cfg_we = 1'b0; bus8.start = 1'b0;
    push_byte(8'hFF, 1'b1, t_acc, ok);
    wait_valid(t_val, ok);
    checks++;
    if (!ok || bus8.res_mask !== ref_mask(8'hFF, 4'b0101)) begin
      errors++; $display("FAIL cfg_busy res_mask: got %b expected %b", bus8.res_mask, ref_mask(8'hFF, 4'b0101));
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_midscan();
    int t_acc, t_val;
    bit ok, seen;
    start_session(4'b1100);
    push_byte(8'h3C, 1'b1, t_acc, ok);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus8.in_ready, bus8.res_valid, bus8.res_hit, bus8.res_mask, bus8.res_offset, bus8.match_count, bus8.busy, bus8.done} !== 21'd0) begin
      errors++; $display("FAIL midscan_reset outputs: got %b expected all zero",
        {bus8.in_ready, bus8.res_valid, bus8.res_hit, bus8.res_mask, bus8.res_offset, bus8.match_count, bus8.busy, bus8.done});
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus8.res_valid || bus8.done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midscan_reset dropped_byte: got result/done 1 expected 0");
    end
    // Pattern register must be cleared: start without cfg_we and scan 0x00.
    @(posedge clk); #1 bus8.start = 1'b1;
    @(posedge clk); #1 bus8.start = 1'b0;
    push_byte(8'h00, 1'b1, t_acc, ok);
    wait_valid(t_val, ok);
    checks++;
    if (!ok || bus8.res_mask !== ref_mask(8'h00, 4'h0)) begin
      errors++; $display("FAIL midscan_reset pattern_cleared: got %b expected %b", bus8.res_mask, ref_mask(8'h00, 4'h0));
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int exp_cnt;
    bit ok;
    exp_cnt = 0;
    @(posedge clk); #1;
    bus2.cfg_we = 1'b1; bus2.cfg_pattern = 4'b0000; bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.cfg_we = 1'b0; bus2.start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus2.in_valid = 1'b1; bus2.in_data = 8'h00; bus2.in_last = (b == 2);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        if (bus2.in_ready) ok = 1'b1;
        @(posedge clk); #1;
      end
      bus2.in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        if (bus2.res_valid) ok = 1'b1;
      end
      @(negedge clk);
      exp_cnt = exp_cnt + $countones(ref_mask(8'h00, 4'b0000));
      if (exp_cnt > 3) exp_cnt = 3;
      checks++;
      if (!ok || int'(bus2.match_count) !== exp_cnt) begin
        errors++; $display("FAIL saturation byte %0d: got %0d expected %0d (valid seen %0b)", b, bus2.match_count, exp_cnt, ok);
      end
    end
    checks++;
    if (bus2.done !== 1'b1) begin
      errors++; $display("FAIL saturation done: got %b expected 1", bus2.done);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bytes_t q;
    logic [3:0] pat;
    logic [7:0] b;
    int n, k;
    for (int s = 0; s < 12; s++) begin
      pat = 4'($urandom);
      n = $urandom_range(1, 4);
      q = {};
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          k = $urandom_range(0, 4);
          b = (b & ~(8'h0F << k)) | ({4'h0, pat} << k);
        end
        q.push_back(b);
      end
      run_session($sformatf("random%0d", s), pat, q);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.cfg_we = 1'b0; bus8.cfg_pattern = 4'h0; bus8.start = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_data = 8'h00; bus8.in_last = 1'b0; bus8.res_ready = 1'b1;
    bus2.cfg_we = 1'b0; bus2.cfg_pattern = 4'h0; bus2.start = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = 8'h00; bus2.in_last = 1'b0; bus2.res_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_cfg_busy();
    test_reset_midscan();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
